hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage RV32 core. Generates forwarding selects for the execute stage, load-use stall and branch flush controls, and sequences a multi-cycle multiply/divide unit occupying execute by freezing F/D/E and bubbling M. It sits beside the pipeline registers and drives their stall and flush enables. It also keeps a saturating stall-cycle counter for performance readout.

## Interface
- MD_LATENCY, 32: execute-stage stall cycles per multi-cycle op; legal range ≥2.
- CNT_WIDTH, 32: stall counter width.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Rs1_D, Rs2_D  in  5  source registers of instruction in decode
- Rs1_E, Rs2_E, Rd_E  in  5  source/dest registers of instruction in execute
- resultSrc_E  in  2  execute result source; 2'b01 = load
- pcSrc_E  in  1  taken branch or jump resolved in execute
- mdStart_E  in  1  instruction in execute is a multi-cycle mul/div
- Rd_M, Rd_W  in  5  destination in memory / writeback
- regWrite_M, regWrite_W  in  1  register write enables in memory / writeback
- forwardA_E, forwardB_E  out  2  00 register file, 01 result_W, 10 ALU result from M
- stall_F, stall_D, stall_E  out  1  hold pipeline register
- flush_D, flush_E, flush_M  out  1  clear pipeline register to bubble
- mdDone  out  1  one-cycle pulse: multi-cycle result valid in execute
- stallCount  out  CNT_WIDTH  cycles with stall_F=1, saturating

## Operation
- Forwarding (per operand, shown for A): 10 if regWrite_M & Rd_M≠0 & Rd_M==Rs1_E; else 01 if regWrite_W & Rd_W≠0 & Rd_W==Rs1_E; else 00. M beats W.
- lwStall = (resultSrc_E==01) & Rd_E≠0 & (Rd_E==Rs1_D | Rd_E==Rs2_D).
- FSM states IDLE, BUSY, DONE; down-counter cnt.
  - IDLE: mdStart_E → BUSY, cnt←MD_LATENCY−2; else stay.
  - BUSY: cnt≠0 → cnt−1; cnt==0 → DONE.
  - DONE: → IDLE unconditionally; mdStart_E ignored (same instruction still in E).
- mdStall = (IDLE & mdStart_E) | BUSY.
- stall_F = stall_D = lwStall | mdStall; stall_E = mdStall; flush_M = mdStall.
- flush_D = pcSrc_E & ~mdStall; flush_E = (pcSrc_E | lwStall) & ~mdStall.
- mdDone = (state==DONE).
- pcSrc_E and mdStart_E are mutually exclusive; if both high, md sequencing wins and pcSrc_E is ignored.
- stallCount increments when stall_F=1, holds at all-ones.

## Timing
- Forwarding, stall and flush outputs combinational from inputs and state; FSM and stallCount registered.
- mdStart_E first seen in IDLE at cycle t: stall_E high cycles t..t+MD_LATENCY−1; mdDone high cycle t+MD_LATENCY; instruction leaves E at end of that cycle. E occupancy = MD_LATENCY+1 cycles.
- Back-to-back md ops: second enters E the cycle after DONE, seen in IDLE, restarts normally; no lost cycle beyond the spec above.
- rst high: state←IDLE, cnt←0, stallCount←0 at the edge; while rst high, combinationally stall_*=0, mdDone=0, forward*=00, flush_D=flush_E=flush_M=1.
- Reset mid-BUSY aborts the op; after rst falls, FSM in IDLE and no mdDone for aborted op.

## Test plan
- Forwarding: Rd_M=Rd_W=Rs1_E=5, regWrite_M=regWrite_W=1 → forwardA_E=10; clear regWrite_M → 01; Rd_M=Rd_W=Rs1_E=0 → 00.
- Load-use: resultSrc_E=01, Rd_E=7, Rs2_D=7 → stall_F=stall_D=flush_E=1, stall_E=0 for one cycle; Rd_E=0 → no stall.
- Branch: pcSrc_E=1 → flush_D=flush_E=1, no stalls; with lwStall also true → still flush, stall_F=1.
- Multi-cycle, MD_LATENCY=4: mdStart_E held from cycle 0 → stall_E=1 cycles 0–3, mdDone=1 cycle 4 only; two ops back-to-back → mdDone at cycles 4 and 9.
- Reset mid-op: rst at cycle 2 of md op → cycle after, all stalls 0, no mdDone, stallCount=0; new mdStart_E runs full MD_LATENCY.
- stallCount with CNT_WIDTH=4: 20 stall cycles → stallCount=15, holds.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-unit control bundle
interface hazard_if #(parameter int CNT_WIDTH = 32);
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] resultSrc_E;
  logic pcSrc_E, mdStart_E, regWrite_M, regWrite_W;
  logic [1:0] forwardA_E, forwardB_E;
  logic stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mdDone;
  logic [CNT_WIDTH-1:0] stallCount;
  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, resultSrc_E,
           pcSrc_E, mdStart_E, regWrite_M, regWrite_W,
    input  forwardA_E, forwardB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mdDone, stallCount
  );
  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, resultSrc_E,
           pcSrc_E, mdStart_E, regWrite_M, regWrite_W,
    output forwardA_E, forwardB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mdDone, stallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall, branch flush and mul/div sequencing
module hazard_unit #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  hazard_if.slave h
);
  localparam int CW = $clog2(MD_LATENCY);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic lw_stall, md_stall;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rd_m,
                                     input logic we_m, input logic [4:0] rd_w, input logic we_w);
    return (we_m && rd_m != 5'd0 && rd_m == rs) ? 2'b10 :
           (we_w && rd_w != 5'd0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction
  // hazard detection; reset forces bubbles everywhere and no stalls
  always_comb begin
    lw_stall = h.resultSrc_E == 2'b01 && h.Rd_E != 5'd0 && (h.Rd_E == h.Rs1_D || h.Rd_E == h.Rs2_D);
    md_stall = (state == IDLE && h.mdStart_E) || state == BUSY;
    h.forwardA_E = rst ? 2'b00 : fwd(h.Rs1_E, h.Rd_M, h.regWrite_M, h.Rd_W, h.regWrite_W);
    h.forwardB_E = rst ? 2'b00 : fwd(h.Rs2_E, h.Rd_M, h.regWrite_M, h.Rd_W, h.regWrite_W);
    h.stall_F = ~rst & (lw_stall | md_stall);
    h.stall_D = ~rst & (lw_stall | md_stall);
    h.stall_E = ~rst & md_stall;
    h.flush_M = rst | md_stall;
    h.flush_D = rst | (h.pcSrc_E & ~md_stall);
    h.flush_E = rst | ((h.pcSrc_E | lw_stall) & ~md_stall);
    h.mdDone  = ~rst & (state == DONE);
  end
  // mul/div occupancy: IDLE start cycle + BUSY countdown, then one DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (h.mdStart_E) begin
          state <= BUSY;
          cnt   <= CW'(MD_LATENCY - 2);
        end
        BUSY: if (cnt == '0) state <= DONE; else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  // saturating count of front-end stall cycles
  always_ff @(posedge clk) begin
    if (rst) h.stallCount <= '0;
    else if (h.stall_F && !(&h.stallCount)) h.stallCount <= h.stallCount + CNT_WIDTH'(1);
  end
endmodule
